// File: rtl/omem_acc_writeback.sv
// Read-modify-write stage between MAC results and OMEM: overwrite or lane-wise
// accumulate (wrapping or saturating), plus a full-range OMEM zero-fill sequence.
module omem_acc_writeback #(
  parameter int unsigned LANES = 4,
  parameter int unsigned LW    = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned SAT   = 0
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                INIT,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                IN_ACC,
  input  logic                IN_LAST,
  input  logic [AW-1:0]       IN_ADDR,
  input  logic [LANES*LW-1:0] IN_DATA,
  output logic                EN_O,
  output logic                RW_O,
  output logic [AW-1:0]       ADDR_O,
  output logic [LANES*LW-1:0] WDATA_O,
  input  logic [LANES*LW-1:0] RDATA_O,
  output logic                DONE,
  output logic                INIT_DONE,
  output logic                OVF
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, WRA, FILL} state_t;

  state_t              state, state_n;
  logic [AW-1:0]       lat_addr;
  logic [LANES*LW-1:0] lat_data;
  logic                lat_last;
  logic [LANES*LW-1:0] sum_q, sum_n;
  logic [LANES-1:0]    lane_ovf;
  logic [AW-1:0]       cnt;
  logic                done_q, init_done_q, ovf_q;
  logic                accepting, take, fill_start, fill_end;

  // Each lane is summed at LW+1 bits; overflow is a disagreement of the top two bits.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [LW:0] s;
    assign s = {RDATA_O[g*LW+LW-1], RDATA_O[g*LW +: LW]}
             + {lat_data[g*LW+LW-1], lat_data[g*LW +: LW]};
    assign lane_ovf[g] = s[LW] ^ s[LW-1];
    assign sum_n[g*LW +: LW] = (SAT != 0 && lane_ovf[g])
                             ? (s[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}})
                             : s[LW-1:0];
  end

  always_comb begin
    accepting  = (state == IDLE) || (state == WR) || (state == WRA);
    IN_READY   = accepting && !INIT && !RSTN;
    take       = IN_READY && IN_VALID;
    fill_start = accepting && INIT;
    fill_end   = (state == FILL) && (cnt == '1);
    state_n    = state;
    case (state)
      IDLE, WR, WRA: begin
        if (INIT)      state_n = FILL;
        else if (take) state_n = IN_ACC ? RD : WR;
        else           state_n = IDLE;
      end
      RD:      state_n = CAP;
      CAP:     state_n = WRA;
      FILL:    state_n = fill_end ? IDLE : FILL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_last    <= 1'b0;
      sum_q       <= '0;
      cnt         <= '0;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state       <= state_n;
      done_q      <= ((state == WR) || (state == WRA)) && lat_last;
      init_done_q <= fill_end;
      if (take) begin
        lat_addr <= IN_ADDR;
        lat_data <= IN_DATA;
        lat_last <= IN_LAST;
      end
      if (state == CAP) begin
        sum_q <= sum_n;
        if (|lane_ovf) ovf_q <= 1'b1;
      end
      // Counter wraps to zero naturally on the final fill increment.
      if (fill_start) begin
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else if (state == FILL) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  always_comb begin
    EN_O    = 1'b0;
    RW_O    = 1'b0;
    ADDR_O  = '0;
    WDATA_O = '0;
    case (state)
      WR: begin
        EN_O = 1'b1; RW_O = 1'b1; ADDR_O = lat_addr; WDATA_O = lat_data;
      end
      RD: begin
        EN_O = 1'b1; ADDR_O = lat_addr;
      end
      WRA: begin
        EN_O = 1'b1; RW_O = 1'b1; ADDR_O = lat_addr; WDATA_O = sum_q;
      end
      FILL: begin
        EN_O = 1'b1; RW_O = 1'b1; ADDR_O = cnt;
      end
      default: ;
    endcase
  end

  assign DONE      = done_q;
  assign INIT_DONE = init_done_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_omem_acc_writeback.sv
// Scoreboard bench: wrap DUT, saturating DUT and an 8x8-bit/AW=3 saturating DUT.
module tb_omem_acc_writeback;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTN;
  logic        init, valid, acc, last;
  logic [3:0]  addr;
  logic [63:0] data;
  logic        c_init, c_valid, c_acc, c_last;
  logic [2:0]  c_addr;
  logic [63:0] c_data;

  logic [2:0]  en, rw, dn, idn, ovf, rdy;
  logic [3:0]  ad0, ad1;
  logic [2:0]  ad2;
  logic [63:0] wd0, wd1, wd2, rd0, rd1, rd2;
  logic [63:0] mem0 [16];
  logic [63:0] mem1 [16];
  logic [63:0] mem2 [8];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
    int          cyc;
    bit          last;
    bit          fin;
  } exp_t;
  exp_t q [3][$];
  bit pd [3];
  bit pf [3];

  omem_acc_writeback #(.LANES(4), .LW(16), .AW(4), .SAT(0)) dut_wrap (
    .CLK(CLK), .RSTN(RSTN), .INIT(init), .IN_VALID(valid), .IN_READY(rdy[0]),
    .IN_ACC(acc), .IN_LAST(last), .IN_ADDR(addr), .IN_DATA(data),
    .EN_O(en[0]), .RW_O(rw[0]), .ADDR_O(ad0), .WDATA_O(wd0), .RDATA_O(rd0),
    .DONE(dn[0]), .INIT_DONE(idn[0]), .OVF(ovf[0]));

  omem_acc_writeback #(.LANES(4), .LW(16), .AW(4), .SAT(1)) dut_sat (
    .CLK(CLK), .RSTN(RSTN), .INIT(init), .IN_VALID(valid), .IN_READY(rdy[1]),
    .IN_ACC(acc), .IN_LAST(last), .IN_ADDR(addr), .IN_DATA(data),
    .EN_O(en[1]), .RW_O(rw[1]), .ADDR_O(ad1), .WDATA_O(wd1), .RDATA_O(rd1),
    .DONE(dn[1]), .INIT_DONE(idn[1]), .OVF(ovf[1]));

  omem_acc_writeback #(.LANES(8), .LW(8), .AW(3), .SAT(1)) dut_small (
    .CLK(CLK), .RSTN(RSTN), .INIT(c_init), .IN_VALID(c_valid), .IN_READY(rdy[2]),
    .IN_ACC(c_acc), .IN_LAST(c_last), .IN_ADDR(c_addr), .IN_DATA(c_data),
    .EN_O(en[2]), .RW_O(rw[2]), .ADDR_O(ad2), .WDATA_O(wd2), .RDATA_O(rd2),
    .DONE(dn[2]), .INIT_DONE(idn[2]), .OVF(ovf[2]));

  // OMEM models; preloaded whenever reset is held.
  always @(posedge CLK) begin
    if (RSTN) begin
      mem0[5] <= 64'h0000_0007_FFFE_0004;
      mem1[5] <= 64'h0000_0007_FFFE_0004;
      mem0[6] <= 64'h0000_0000_8000_7FFF;
      mem1[6] <= 64'h0000_0000_8000_7FFF;
      mem2[2] <= 64'h7F7F_7F7F_7F7F_7F7F;
    end else begin
      if (en[0]) begin if (rw[0]) mem0[ad0] <= wd0; else rd0 <= mem0[ad0]; end
      if (en[1]) begin if (rw[1]) mem1[ad1] <= wd1; else rd1 <= mem1[ad1]; end
      if (en[2]) begin if (rw[2]) mem2[ad2] <= wd2; else rd2 <= mem2[ad2]; end
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input int d, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual %h required %h (cycle %0d)", n, d, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin
    logic [3:0]  a;
    logic [63:0] w;
    exp_t        e;
    for (int d = 0; d < 3; d++) begin
      a = (d == 0) ? ad0 : (d == 1) ? ad1 : {1'b0, ad2};
      w = (d == 0) ? wd0 : (d == 1) ? wd1 : wd2;
      if (dn[d] || pd[d])  chk("done_pulse", d, 64'(dn[d]), 64'(pd[d]));
      if (idn[d] || pf[d]) chk("init_done_pulse", d, 64'(idn[d]), 64'(pf[d]));
      pd[d] = 1'b0;
      pf[d] = 1'b0;
      if (en[d] === 1'b1 && rw[d] === 1'b1) begin
        if (q[d].size() == 0) begin
          chk("unexpected_write", d, 64'(a), 64'hFFFF);
        end else begin
          e = q[d].pop_front();
          chk("write_addr", d, 64'(a), 64'(e.a));
          chk("write_data", d, w, e.d);
          chk("write_cycle", d, 64'(cyc), 64'(e.cyc));
          pd[d] = e.last;
          pf[d] = e.fin;
        end
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] a, input logic [63:0] d, input int c,
                              input bit l, input bit f);
    exp_t e;
    e.a = a; e.d = d; e.cyc = c; e.last = l; e.fin = f;
    return e;
  endfunction

  task automatic send(input int d, input bit s_acc, input bit s_last, input logic [3:0] s_addr,
                      input logic [63:0] s_data, output int k);
    int n;
    if (d == 2) begin
      c_valid = 1'b1; c_acc = s_acc; c_last = s_last; c_addr = s_addr[2:0]; c_data = s_data;
    end else begin
      valid = 1'b1; acc = s_acc; last = s_last; addr = s_addr; data = s_data;
    end
    n = 0;
    while (rdy[d] !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n == 20) chk("accept_timeout", d, 64'(n), 64'd0);
    @(posedge CLK); #1;
    k = cyc;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; c_valid = 1'b0;
  endtask

  task automatic check_quiet(input int d, input string n);
    chk({n, "_en"}, d, 64'(en[d]), 64'd0);
    chk({n, "_rw"}, d, 64'(rw[d]), 64'd0);
    chk({n, "_addr"}, d, (d == 0) ? 64'(ad0) : (d == 1) ? 64'(ad1) : 64'(ad2), 64'd0);
    chk({n, "_wdata"}, d, (d == 0) ? wd0 : (d == 1) ? wd1 : wd2, 64'd0);
    chk({n, "_done"}, d, 64'(dn[d]), 64'd0);
    chk({n, "_init_done"}, d, 64'(idn[d]), 64'd0);
    chk({n, "_ovf"}, d, 64'(ovf[d]), 64'd0);
    chk({n, "_ready"}, d, 64'(rdy[d]), 64'd0);
  endtask

  logic [63:0] burst [4];
  initial begin
    int k, k0, n;
    burst[0] = 64'h1234_5678_9ABC_DEF0;
    burst[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    burst[2] = 64'h0001_0002_0003_0004;
    burst[3] = 64'hFFFF_8000_7FFF_0000;
    RSTN = 1'b1;
    init = 1'b0; valid = 1'b0; acc = 1'b0; last = 1'b0; addr = '0; data = '0;
    c_init = 1'b0; c_valid = 1'b0; c_acc = 1'b0; c_last = 1'b0; c_addr = '0; c_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < 3; d++) check_quiet(d, "reset");
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Overwrite burst: one write per cycle, last flag on the final one.
    k0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, i == 3, 4'(i), burst[i], k);
      if (i == 0) k0 = k;
      chk("burst_back_to_back", 0, 64'(k), 64'(k0 + i));
      q[0].push_back(mk(4'(i), burst[i], k, i == 3, 1'b0));
      q[1].push_back(mk(4'(i), burst[i], k, i == 3, 1'b0));
    end
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;

    // Accumulate {4,-2,7,0} + {1,2,-7,-1} at row 5.
    send(0, 1'b1, 1'b1, 4'd5, 64'hFFFF_FFF9_0002_0001, k);
    idle_inputs();
    q[0].push_back(mk(4'd5, 64'hFFFF_0000_0000_0005, k + 2, 1'b1, 1'b0));
    q[1].push_back(mk(4'd5, 64'hFFFF_0000_0000_0005, k + 2, 1'b1, 1'b0));
    chk("acc_ready_rd", 0, 64'(rdy[0]), 64'd0);
    @(posedge CLK); #1;
    chk("acc_ready_cap", 0, 64'(rdy[0]), 64'd0);
    @(posedge CLK); #1;
    chk("acc_ready_wra", 0, 64'(rdy[0]), 64'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("acc_no_ovf", 0, 64'(ovf[0]), 64'd0);
    chk("acc_no_ovf", 1, 64'(ovf[1]), 64'd0);

    // Saturation at row 6: lanes {0x7FFF, 0x8000, 0, 0} + {1, -1, 3, -1}.
    send(0, 1'b1, 1'b0, 4'd6, 64'hFFFF_0003_FFFF_0001, k);
    idle_inputs();
    q[0].push_back(mk(4'd6, 64'hFFFF_0003_7FFF_8000, k + 2, 1'b0, 1'b0));
    q[1].push_back(mk(4'd6, 64'hFFFF_0003_8000_7FFF, k + 2, 1'b0, 1'b0));
    repeat (4) @(posedge CLK);
    #1;
    chk("sat_ovf", 0, 64'(ovf[0]), 64'd1);
    chk("sat_ovf", 1, 64'(ovf[1]), 64'd1);

    // Zero-fill, with a competing request that must not be taken.
    init = 1'b1; valid = 1'b1; acc = 1'b0; addr = 4'd9; data = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("init_blocks_ready", 0, 64'(rdy[0]), 64'd0);
    @(posedge CLK); #1;
    k = cyc;
    init = 1'b0; valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q[0].push_back(mk(4'(i), 64'd0, k + i, 1'b0, i == 15));
      q[1].push_back(mk(4'(i), 64'd0, k + i, 1'b0, i == 15));
    end
    #1;
    chk("fill_ready_low", 0, 64'(rdy[0]), 64'd0);
    chk("fill_clears_ovf", 1, 64'(ovf[1]), 64'd0);
    repeat (17) @(posedge CLK);
    #1;
    chk("fill_ovf", 0, 64'(ovf[0]), 64'd0);
    chk("fill_ready_back", 0, 64'(rdy[0]), 64'd1);
    chk("fill_ready_back", 1, 64'(rdy[1]), 64'd1);

    // Reset while the accumulate sits in CAP: no write must follow.
    send(0, 1'b1, 1'b1, 4'd3, 64'h0001_0001_0001_0001, k);
    idle_inputs();
    @(posedge CLK); #1;
    RSTN = 1'b1;
    #1;
    check_quiet(0, "midreset");
    check_quiet(1, "midreset");
    @(posedge CLK); #1;
    RSTN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // 8x8-bit saturating instance: 127 + 1 per lane stays 127.
    send(2, 1'b1, 1'b1, 4'd2, 64'h0101_0101_0101_0101, k);
    idle_inputs();
    q[2].push_back(mk(4'd2, 64'h7F7F_7F7F_7F7F_7F7F, k + 2, 1'b1, 1'b0));
    repeat (4) @(posedge CLK);
    #1;
    chk("small_ovf", 2, 64'(ovf[2]), 64'd1);
    c_init = 1'b1;
    @(posedge CLK); #1;
    k = cyc;
    c_init = 1'b0;
    for (int i = 0; i < 8; i++) q[2].push_back(mk(4'(i), 64'd0, k + i, 1'b0, i == 7));
    repeat (9) @(posedge CLK);
    #1;
    chk("small_fill_ovf", 2, 64'(ovf[2]), 64'd0);
    chk("small_fill_ready", 2, 64'(rdy[2]), 64'd1);

    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    for (int d = 0; d < 3; d++) chk("pending_writes", d, 64'(q[d].size()), 64'd0);
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
